// File: rtl/mem_arbiter.sv
// rtl/mem_arbiter.sv - round-robin arbiter sharing one line-wide memory port between two caches
//
// Port 0 (instruction cache) and port 1 (data cache) compete for a single
// line-wide main-memory port. One transaction owns memory from grant until
// mem_ready or the watchdog fires. The winning request is captured at grant
// time, so the memory-side signals stay stable even if the requester changes
// its inputs.
//
// Ports:
//   clk, rst                 clock, synchronous active-low reset
//   cN_req/we/addr/wdata     port N request, direction, line address, write line
//   cN_rdata/ready           port N read line and one-cycle completion pulse
//   mem_req/we/addr/wdata    memory request side, zero while mem_req=0
//   mem_rdata/ready          memory response side
//   busy                     high whenever the FSM is not idle
//   owner                    port of the current or most recent grant
//   timeout_err              sticky watchdog flag, cleared only by reset

module mem_arbiter #(
  parameter int AW        = 32,
  parameter int LW        = 128,
  parameter int TIMEOUT   = 1023,
  parameter bit PRIO_INIT = 1'b0
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          c0_req,
  input  logic          c0_we,
  input  logic [AW-1:0] c0_addr,
  input  logic [LW-1:0] c0_wdata,
  output logic [LW-1:0] c0_rdata,
  output logic          c0_ready,
  input  logic          c1_req,
  input  logic          c1_we,
  input  logic [AW-1:0] c1_addr,
  input  logic [LW-1:0] c1_wdata,
  output logic [LW-1:0] c1_rdata,
  output logic          c1_ready,
  output logic          mem_req,
  output logic          mem_we,
  output logic [AW-1:0] mem_addr,
  output logic [LW-1:0] mem_wdata,
  input  logic [LW-1:0] mem_rdata,
  input  logic          mem_ready,
  output logic          busy,
  output logic          owner,
  output logic          timeout_err
);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    ISSUE   = 2'd1,
    RELEASE = 2'd2
  } state_t;

  // A zero TIMEOUT disables the watchdog; keep the counter at least one bit wide.
  localparam int            CW       = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;
  localparam logic [CW-1:0] CNT_LAST = CW'((TIMEOUT > 0) ? (TIMEOUT - 1) : 0);
  localparam bit            WDOG_ON  = (TIMEOUT != 0);

  state_t        state;
  logic          prio;
  logic          owner_q;
  logic [CW-1:0] cnt;
  logic          lat_we;
  logic [AW-1:0] lat_addr;
  logic [LW-1:0] lat_wdata;
  logic          err_q;

  logic in_issue;
  logic tmo_hit;
  logic done;
  logic gnt_port;

  assign in_issue = (state == ISSUE);
  assign tmo_hit  = WDOG_ON && (cnt == CNT_LAST);
  assign done     = in_issue && (mem_ready || tmo_hit);
  // Contention goes to prio; otherwise whichever port asks (c1_req alone -> 1).
  assign gnt_port = (c0_req && c1_req) ? prio : c1_req;

  always_ff @(posedge clk) begin
    if (!rst) begin
      state     <= IDLE;
      prio      <= PRIO_INIT;
      owner_q   <= 1'b0;
      cnt       <= '0;
      lat_we    <= 1'b0;
      lat_addr  <= '0;
      lat_wdata <= '0;
      err_q     <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (c0_req || c1_req) begin
            owner_q   <= gnt_port;
            lat_we    <= gnt_port ? c1_we    : c0_we;
            lat_addr  <= gnt_port ? c1_addr  : c0_addr;
            lat_wdata <= gnt_port ? c1_wdata : c0_wdata;
            cnt       <= '0;
            state     <= ISSUE;
          end
        end
        ISSUE: begin
          if (mem_ready) begin
            // A response arriving on the watchdog cycle still counts as success.
            prio  <= ~owner_q;
            state <= RELEASE;
          end else if (tmo_hit) begin
            err_q <= 1'b1;
            prio  <= ~owner_q;
            state <= RELEASE;
          end else if (cnt != '1) begin
            cnt <= cnt + CW'(1);
          end
        end
        RELEASE: state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

  assign mem_req   = in_issue;
  assign mem_we    = in_issue && lat_we;
  assign mem_addr  = in_issue ? lat_addr  : '0;
  assign mem_wdata = in_issue ? lat_wdata : '0;

  // Completion is suppressed while reset is asserted so an abandoned
  // transaction never signals the cache.
  assign c0_ready = rst && done && !owner_q;
  assign c1_ready = rst && done &&  owner_q;
  assign c0_rdata = (rst && in_issue && mem_ready && !owner_q) ? mem_rdata : '0;
  assign c1_rdata = (rst && in_issue && mem_ready &&  owner_q) ? mem_rdata : '0;

  assign busy        = (state != IDLE);
  assign owner       = owner_q;
  assign timeout_err = err_q;

endmodule

// File: tb/tb_mem_arbiter.sv
// tb/tb_mem_arbiter.sv - directed self-checking bench for mem_arbiter

module tb_mem_arbiter;

  localparam int AW = 32;
  localparam int LW = 128;

  logic          clk;
  logic          rst;
  logic          c0_req, c0_we, c1_req, c1_we;
  logic [AW-1:0] c0_addr, c1_addr;
  logic [LW-1:0] c0_wdata, c1_wdata, c0_rdata, c1_rdata;
  logic          c0_ready, c1_ready;
  logic          mem_req, mem_we, mem_ready;
  logic [AW-1:0] mem_addr;
  logic [LW-1:0] mem_wdata, mem_rdata;
  logic          busy, owner, timeout_err;

  int errors = 0;
  int checks = 0;

  logic [LW-1:0] rd_line = {4{32'hDEADBEEF}};
  logic [LW-1:0] wb_line = 128'h0123456789ABCDEF_0123456789ABCDEF;
  logic [LW-1:0] r0_line = 128'h11112222_33334444_55556666_77778888;
  logic [LW-1:0] r1_line = 128'hA5A5A5A5_5A5A5A5A_C3C3C3C3_3C3C3C3C;

  mem_arbiter #(.AW(AW), .LW(LW), .TIMEOUT(8), .PRIO_INIT(1'b0)) dut (
    .clk(clk), .rst(rst),
    .c0_req(c0_req), .c0_we(c0_we), .c0_addr(c0_addr), .c0_wdata(c0_wdata),
    .c0_rdata(c0_rdata), .c0_ready(c0_ready),
    .c1_req(c1_req), .c1_we(c1_we), .c1_addr(c1_addr), .c1_wdata(c1_wdata),
    .c1_rdata(c1_rdata), .c1_ready(c1_ready),
    .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_rdata(mem_rdata), .mem_ready(mem_ready),
    .busy(busy), .owner(owner), .timeout_err(timeout_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish within time limit");
    $fatal(1);
  end

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset;
    rst = 1'b0;
    tick();
    rst = 1'b1;
  endtask

  task automatic test_reset;
    rst = 1'b0; c0_req = 1'b1; c1_req = 1'b1;
    tick(); tick();
    @(negedge clk);
    checks++; if (mem_req !== 1'b0) begin errors++; $display("FAIL rst_mem_req: got %b want 0", mem_req); end
    checks++; if (c0_ready !== 1'b0) begin errors++; $display("FAIL rst_c0_ready: got %b want 0", c0_ready); end
    checks++; if (c1_ready !== 1'b0) begin errors++; $display("FAIL rst_c1_ready: got %b want 0", c1_ready); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL rst_busy: got %b want 0", busy); end
    checks++; if (owner !== 1'b0) begin errors++; $display("FAIL rst_owner: got %b want 0", owner); end
    checks++; if (timeout_err !== 1'b0) begin errors++; $display("FAIL rst_timeout_err: got %b want 0", timeout_err); end
    c0_req = 1'b0; c1_req = 1'b0; rst = 1'b1;
    tick();
  endtask

  task automatic test_read;
    c0_we = 1'b0; c0_addr = 32'h0000_1230; c0_req = 1'b1;
    @(negedge clk);
    checks++; if (mem_req !== 1'b0) begin errors++; $display("FAIL rd_pre_mem_req: got %b want 0", mem_req); end
    tick();
    for (int i = 1; i <= 4; i++) begin
      if (i == 4) begin mem_ready = 1'b1; mem_rdata = rd_line; end
      @(negedge clk);
      checks++; if (mem_req !== 1'b1) begin errors++; $display("FAIL rd_mem_req c%0d: got %b want 1", i, mem_req); end
      checks++; if (mem_addr !== 32'h0000_1230) begin errors++; $display("FAIL rd_mem_addr c%0d: got %h want 00001230", i, mem_addr); end
      checks++; if (mem_we !== 1'b0) begin errors++; $display("FAIL rd_mem_we c%0d: got %b want 0", i, mem_we); end
      checks++; if (c0_ready !== (i == 4)) begin errors++; $display("FAIL rd_c0_ready c%0d: got %b want %b", i, c0_ready, (i == 4)); end
      checks++; if (c1_ready !== 1'b0) begin errors++; $display("FAIL rd_c1_ready c%0d: got %b want 0", i, c1_ready); end
      if (i == 4) begin
        checks++; if (c0_rdata !== rd_line) begin errors++; $display("FAIL rd_c0_rdata: got %h want %h", c0_rdata, rd_line); end
        checks++; if (c1_rdata !== '0) begin errors++; $display("FAIL rd_c1_rdata: got %h want 0", c1_rdata); end
      end
      tick();
    end
    mem_ready = 1'b0; c0_req = 1'b0;
    @(negedge clk);
    checks++; if (c0_ready !== 1'b0) begin errors++; $display("FAIL rd_rel_c0_ready: got %b want 0", c0_ready); end
    checks++; if (mem_req !== 1'b0) begin errors++; $display("FAIL rd_rel_mem_req: got %b want 0", mem_req); end
    checks++; if (busy !== 1'b1) begin errors++; $display("FAIL rd_rel_busy: got %b want 1", busy); end
    tick();
    @(negedge clk);
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL rd_idle_busy: got %b want 0", busy); end
    tick();
  endtask

  task automatic test_round_robin;
    logic exp_req, exp_own;
    do_reset();
    c0_we = 1'b0; c0_addr = 32'h0000_0100; c1_we = 1'b0; c1_addr = 32'h0000_0200;
    c0_req = 1'b1; c1_req = 1'b1; mem_ready = 1'b1; mem_rdata = r0_line;
    for (int k = 0; k < 12; k++) begin
      exp_req = (k % 3 == 1);
      exp_own = ((k / 3) % 2) == 1;
      @(negedge clk);
      checks++; if (mem_req !== exp_req) begin errors++; $display("FAIL rr_mem_req k%0d: got %b want %b", k, mem_req, exp_req); end
      if (exp_req) begin
        checks++; if (owner !== exp_own) begin errors++; $display("FAIL rr_owner k%0d: got %b want %b", k, owner, exp_own); end
      end
      checks++; if (c0_ready !== (exp_req && !exp_own)) begin errors++; $display("FAIL rr_c0_ready k%0d: got %b want %b", k, c0_ready, (exp_req && !exp_own)); end
      checks++; if (c1_ready !== (exp_req && exp_own)) begin errors++; $display("FAIL rr_c1_ready k%0d: got %b want %b", k, c1_ready, (exp_req && exp_own)); end
      tick();
    end
    c0_req = 1'b0; c1_req = 1'b0; mem_ready = 1'b0;
    tick(); tick();
  endtask

  task automatic test_back_to_back;
    do_reset();
    c1_req = 1'b1; c1_we = 1'b1; c1_addr = 32'h0000_2000; c1_wdata = wb_line; c0_req = 1'b0;
    @(negedge clk);
    checks++; if (mem_req !== 1'b0) begin errors++; $display("FAIL bb_pre_mem_req: got %b want 0", mem_req); end
    tick();
    c0_req = 1'b1; c0_we = 1'b0; c0_addr = 32'h0000_3000;
    for (int i = 1; i <= 3; i++) begin
      if (i == 2) begin c1_wdata = ~wb_line; c1_addr = 32'h0000_FFF0; c1_we = 1'b0; end
      if (i == 3) begin mem_ready = 1'b1; mem_rdata = '0; end
      @(negedge clk);
      checks++; if (owner !== 1'b1) begin errors++; $display("FAIL bb_wb_owner c%0d: got %b want 1", i, owner); end
      checks++; if (mem_we !== 1'b1) begin errors++; $display("FAIL bb_wb_we c%0d: got %b want 1", i, mem_we); end
      checks++; if (mem_addr !== 32'h0000_2000) begin errors++; $display("FAIL bb_wb_addr c%0d: got %h want 00002000", i, mem_addr); end
      checks++; if (mem_wdata !== wb_line) begin errors++; $display("FAIL bb_wb_wdata c%0d: got %h want %h", i, mem_wdata, wb_line); end
      checks++; if (c1_ready !== (i == 3)) begin errors++; $display("FAIL bb_wb_c1_ready c%0d: got %b want %b", i, c1_ready, (i == 3)); end
      checks++; if (c0_ready !== 1'b0) begin errors++; $display("FAIL bb_wb_c0_ready c%0d: got %b want 0", i, c0_ready); end
      tick();
    end
    mem_ready = 1'b0; c1_we = 1'b0; c1_addr = 32'h0000_4000; c1_wdata = '0;
    @(negedge clk);
    checks++; if (mem_req !== 1'b0) begin errors++; $display("FAIL bb_rel_mem_req: got %b want 0", mem_req); end
    checks++; if (mem_wdata !== '0) begin errors++; $display("FAIL bb_rel_wdata: got %h want 0", mem_wdata); end
    tick();
    @(negedge clk);
    checks++; if (mem_req !== 1'b0) begin errors++; $display("FAIL bb_idle_mem_req: got %b want 0", mem_req); end
    tick();
    mem_ready = 1'b1; mem_rdata = r0_line;
    @(negedge clk);
    checks++; if (owner !== 1'b0) begin errors++; $display("FAIL bb_c0_owner: got %b want 0", owner); end
    checks++; if (mem_addr !== 32'h0000_3000) begin errors++; $display("FAIL bb_c0_addr: got %h want 00003000", mem_addr); end
    checks++; if (c0_ready !== 1'b1) begin errors++; $display("FAIL bb_c0_ready: got %b want 1", c0_ready); end
    checks++; if (c0_rdata !== r0_line) begin errors++; $display("FAIL bb_c0_rdata: got %h want %h", c0_rdata, r0_line); end
    checks++; if (c1_rdata !== '0) begin errors++; $display("FAIL bb_c0_c1_rdata: got %h want 0", c1_rdata); end
    tick();
    mem_ready = 1'b0;
    tick(); tick();
    mem_ready = 1'b1; mem_rdata = r1_line;
    @(negedge clk);
    checks++; if (owner !== 1'b1) begin errors++; $display("FAIL bb_rf_owner: got %b want 1", owner); end
    checks++; if (mem_addr !== 32'h0000_4000) begin errors++; $display("FAIL bb_rf_addr: got %h want 00004000", mem_addr); end
    checks++; if (mem_we !== 1'b0) begin errors++; $display("FAIL bb_rf_we: got %b want 0", mem_we); end
    checks++; if (c1_ready !== 1'b1) begin errors++; $display("FAIL bb_rf_c1_ready: got %b want 1", c1_ready); end
    checks++; if (c1_rdata !== r1_line) begin errors++; $display("FAIL bb_rf_c1_rdata: got %h want %h", c1_rdata, r1_line); end
    checks++; if (c0_ready !== 1'b0) begin errors++; $display("FAIL bb_rf_c0_ready: got %b want 0", c0_ready); end
    tick();
    mem_ready = 1'b0; c0_req = 1'b0; c1_req = 1'b0;
    tick(); tick();
  endtask

  task automatic test_timeout;
    do_reset();
    c0_req = 1'b1; c0_we = 1'b0; c0_addr = 32'h0000_5000; mem_ready = 1'b0; mem_rdata = rd_line;
    @(negedge clk);
    checks++; if (timeout_err !== 1'b0) begin errors++; $display("FAIL to_pre_err: got %b want 0", timeout_err); end
    tick();
    for (int i = 1; i <= 8; i++) begin
      @(negedge clk);
      checks++; if (mem_req !== 1'b1) begin errors++; $display("FAIL to_mem_req c%0d: got %b want 1", i, mem_req); end
      checks++; if (c0_ready !== (i == 8)) begin errors++; $display("FAIL to_c0_ready c%0d: got %b want %b", i, c0_ready, (i == 8)); end
      checks++; if (timeout_err !== 1'b0) begin errors++; $display("FAIL to_err_early c%0d: got %b want 0", i, timeout_err); end
      if (i == 8) begin
        checks++; if (c0_rdata !== '0) begin errors++; $display("FAIL to_c0_rdata: got %h want 0", c0_rdata); end
      end
      tick();
    end
    c0_req = 1'b0;
    @(negedge clk);
    checks++; if (timeout_err !== 1'b1) begin errors++; $display("FAIL to_err_set: got %b want 1", timeout_err); end
    checks++; if (mem_req !== 1'b0) begin errors++; $display("FAIL to_rel_mem_req: got %b want 0", mem_req); end
    tick(); tick(); tick();
    @(negedge clk);
    checks++; if (timeout_err !== 1'b1) begin errors++; $display("FAIL to_err_sticky: got %b want 1", timeout_err); end
    tick();
    do_reset();
    @(negedge clk);
    checks++; if (timeout_err !== 1'b0) begin errors++; $display("FAIL to_err_cleared: got %b want 0", timeout_err); end
    c0_req = 1'b1;
    tick();
    for (int i = 1; i <= 8; i++) begin
      if (i == 8) begin mem_ready = 1'b1; mem_rdata = r1_line; end
      @(negedge clk);
      checks++; if (c0_ready !== (i == 8)) begin errors++; $display("FAIL tie_c0_ready c%0d: got %b want %b", i, c0_ready, (i == 8)); end
      if (i == 8) begin
        checks++; if (c0_rdata !== r1_line) begin errors++; $display("FAIL tie_c0_rdata: got %h want %h", c0_rdata, r1_line); end
      end
      tick();
    end
    mem_ready = 1'b0; c0_req = 1'b0;
    @(negedge clk);
    checks++; if (timeout_err !== 1'b0) begin errors++; $display("FAIL tie_err: got %b want 0", timeout_err); end
    tick(); tick();
  endtask

  task automatic test_reset_midflight;
    do_reset();
    c1_req = 1'b1; c1_we = 1'b0; c1_addr = 32'h0000_6000;
    tick();
    @(negedge clk);
    checks++; if (mem_req !== 1'b1) begin errors++; $display("FAIL mr_mem_req: got %b want 1", mem_req); end
    tick();
    rst = 1'b0; mem_ready = 1'b1; mem_rdata = rd_line;
    @(negedge clk);
    checks++; if (c1_ready !== 1'b0) begin errors++; $display("FAIL mr_c1_ready: got %b want 0", c1_ready); end
    checks++; if (c1_rdata !== '0) begin errors++; $display("FAIL mr_c1_rdata: got %h want 0", c1_rdata); end
    tick();
    rst = 1'b1; mem_ready = 1'b0; c1_req = 1'b0;
    @(negedge clk);
    checks++; if (mem_req !== 1'b0) begin errors++; $display("FAIL mr_after_mem_req: got %b want 0", mem_req); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL mr_after_busy: got %b want 0", busy); end
    checks++; if (owner !== 1'b0) begin errors++; $display("FAIL mr_after_owner: got %b want 0", owner); end
    checks++; if (c1_ready !== 1'b0) begin errors++; $display("FAIL mr_after_c1_ready: got %b want 0", c1_ready); end
    tick();
  endtask

  initial begin
    rst = 1'b0;
    c0_req = 1'b0; c0_we = 1'b0; c0_addr = '0; c0_wdata = '0;
    c1_req = 1'b0; c1_we = 1'b0; c1_addr = '0; c1_wdata = '0;
    mem_rdata = '0; mem_ready = 1'b0;
    test_reset();
    test_read();
    test_round_robin();
    test_back_to_back();
    test_timeout();
    test_reset_midflight();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
